// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage sitting between fetch and execute. Each
// accepted instruction is decoded into raw fields, a sign-extended immediate,
// a 7-bit control vector and an illegal flag, then held in a valid/ready
// pipeline register. With SKID=1 a second entry absorbs one beat while the
// output is stalled, so in_ready depends only on registered state.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising clock edge. valid never depends on ready. Once
// out_valid is high, the payload stays constant until out_ready is seen.
//
// Configuration macro: DECODE_RV32M_EN
//   defined     -> OP with funct7=0000001 (RV32M) is legal, ctrl=1000000
//   not defined -> that encoding is illegal like any other bad funct7
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch-side handshake
//   in_inst, in_pc        instruction word and its PC
//   flush                 drop every held and incoming entry this cycle
//   out_valid/out_ready   execute-side handshake
//   out_pc                PC of the held entry
//   out_opcode/rd/rs1/rs2/funct3/funct7  raw instruction fields
//   out_imm               sign-extended immediate (0 for R-type/illegal)
//   out_ctrl              {reg_write,alu_src,mem_read,mem_write,mem_to_reg,
//                          branch,jump}, 0 when illegal
//   out_illegal           entry is an illegal encoding
//   illegal_cnt           saturating count of illegal entries handed out
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output logic [XLEN-1:0]  out_imm,
   output logic [6:0]       out_ctrl,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic [6:0]      ctrl;
      logic            illegal;
   } entry_t;

   // ---------------------------------------------------------------- decode
   entry_t             w_dec;
   logic        [31:0] w_imm32;
   logic        [6:0]  w_ctrl;
   logic               w_legal;
   logic        [2:0]  w_f3;
   logic        [6:0]  w_f7;
   logic               w_f7_zero;
   logic               w_f7_alt;

   assign w_f3      = in_inst[14:12];
   assign w_f7      = in_inst[31:25];
   assign w_f7_zero = (w_f7 == 7'b0000000);
   assign w_f7_alt  = (w_f7 == 7'b0100000);

   always_comb begin
      w_imm32 = '0;
      w_ctrl  = '0;
      w_legal = 1'b0;
      case (in_inst[6:0])
         OPC_OP: begin
            // funct7=0100000 only exists for SUB and SRA
            w_legal = w_f7_zero || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101));
`ifdef DECODE_RV32M_EN
            if (w_f7 == 7'b0000001) w_legal = 1'b1;
`endif
            w_ctrl  = 7'b1000000;
         end
         OPC_OP_IMM: begin
            // shift-immediates reuse the funct7 slot of the I-immediate
            w_legal = !((w_f3 == 3'b001) && !w_f7_zero) &&
                      !((w_f3 == 3'b101) && !w_f7_zero && !w_f7_alt);
            w_ctrl  = 7'b1100000;
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_LOAD: begin
            w_legal = !(w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
            w_ctrl  = 7'b1110100;
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_STORE: begin
            w_legal = (w_f3 < 3'b011);
            w_ctrl  = 7'b0101000;
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         OPC_BRANCH: begin
            w_legal = !(w_f3 == 3'b010 || w_f3 == 3'b011);
            w_ctrl  = 7'b0000010;
            w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            w_legal = 1'b1;
            w_ctrl  = 7'b1100000;
            w_imm32 = {in_inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            w_legal = 1'b1;
            w_ctrl  = 7'b1000001;
            w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};
         end
         OPC_JALR: begin
            w_legal = (w_f3 == 3'b000);
            w_ctrl  = 7'b1100001;
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         default: w_legal = 1'b0;
      endcase
      if (in_inst[1:0] != 2'b11) w_legal = 1'b0;
   end

   always_comb begin
      w_dec         = '0;
      w_dec.pc      = in_pc;
      w_dec.opcode  = in_inst[6:0];
      w_dec.rd      = in_inst[11:7];
      w_dec.rs1     = in_inst[19:15];
      w_dec.rs2     = in_inst[24:20];
      w_dec.funct3  = w_f3;
      w_dec.funct7  = w_f7;
      w_dec.illegal = !w_legal;
      // illegal entries still flow so execute can trap, but carry no ctrl/imm
      if (w_legal) begin
         w_dec.ctrl = w_ctrl;
         w_dec.imm  = XLEN'($signed(w_imm32));
      end
   end

   // ------------------------------------------------------- pipeline register
   entry_t           r_out;
   entry_t           r_skid;
   logic             r_out_valid;
   logic             r_skid_valid;
   logic             r_rdy_en;
   logic [CNT_W-1:0] r_cnt;
   logic             w_in_fire;
   logic             w_out_fire;

   // r_rdy_en keeps in_ready low during reset and for the release edge
   assign in_ready   = r_rdy_en & ((SKID != 0) ? !r_skid_valid
                                               : (!r_out_valid | out_ready));
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en     <= 1'b0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out        <= '0;
         r_skid       <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (!r_out_valid || out_ready) begin
            // output slot frees up: older skid entry has priority (in order);
            // in_ready is low whenever the skid is full, so no input collides
            if (r_skid_valid) begin
               r_out        <= r_skid;
               r_out_valid  <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
               r_out       <= w_dec;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_in_fire && (SKID != 0)) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!flush && w_out_fire && r_out.illegal && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_pc      = r_out.pc;
   assign out_opcode  = r_out.opcode;
   assign out_rd      = r_out.rd;
   assign out_rs1     = r_out.rs1;
   assign out_rs2     = r_out.rs2;
   assign out_funct3  = r_out.funct3;
   assign out_funct7  = r_out.funct7;
   assign out_imm     = r_out.imm;
   assign out_ctrl    = r_out.ctrl;
   assign out_illegal = r_out.illegal;
   assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [31:0]      in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [6:0]       out_opcode;
   logic [4:0]       out_rd;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [2:0]       out_funct3;
   logic [6:0]       out_funct7;
   logic [31:0]      out_imm;
   logic [6:0]       out_ctrl;
   logic             out_illegal;
   logic [CNT_W-1:0] illegal_cnt;

   decode_stage #(.XLEN(32), .PC_W(32), .SKID(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
      .out_ctrl(out_ctrl), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   // ------------------------------------------------------ clock / reset
   always #5 clk = ~clk;

   // ------------------------------------------------------ scoreboard state
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] fields;  // {opcode,rd,rs1,rs2,funct3,funct7}
      logic [31:0] imm;
      logic [6:0]  ctrl;
      logic        ill;
   } ent_t;

   ent_t exp_q[$];
   int   model_cnt = 0;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decoder: immediates assembled arithmetically from the
   // instruction's bit groups, legality from the list of allowed encodings.
   function automatic ent_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
      ent_t e;
      int   v;
      bit   ok;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = inst[6:0];
      f3 = inst[14:12];
      f7 = inst[31:25];
      v  = 0;
      ok = 1'b0;
      e  = '0;
      e.pc     = pc;
      e.fields = {op, inst[11:7], inst[19:15], inst[24:20], f3, f7};
      case (op)
         7'h33: begin
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
`ifdef DECODE_RV32M_EN
            if (f7 == 7'h01) ok = 1'b1;
`endif
            e.ctrl = 7'b1000000;
         end
         7'h13: begin
            ok = 1'b1;
            if (f3 == 1 && f7 != 0) ok = 1'b0;
            if (f3 == 5 && f7 != 0 && f7 != 7'h20) ok = 1'b0;
            v = int'(inst[31:20]); if (v >= 2048) v -= 4096;
            e.ctrl = 7'b1100000;
         end
         7'h03: begin
            ok = !(f3 == 3 || f3 == 6 || f3 == 7);
            v = int'(inst[31:20]); if (v >= 2048) v -= 4096;
            e.ctrl = 7'b1110100;
         end
         7'h23: begin
            ok = (f3 <= 2);
            v = int'(inst[31:25]) * 32 + int'(inst[11:7]); if (v >= 2048) v -= 4096;
            e.ctrl = 7'b0101000;
         end
         7'h63: begin
            ok = !(f3 == 2 || f3 == 3);
            v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            if (inst[31]) v -= 4096;
            e.ctrl = 7'b0000010;
         end
         7'h37, 7'h17: begin
            ok = 1'b1;
            v = int'(inst[31:12]) * 4096;
            e.ctrl = 7'b1100000;
         end
         7'h6F: begin
            ok = 1'b1;
            v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            if (inst[31]) v -= (1 << 20);
            e.ctrl = 7'b1000001;
         end
         7'h67: begin
            ok = (f3 == 0);
            v = int'(inst[31:20]); if (v >= 2048) v -= 4096;
            e.ctrl = 7'b1100001;
         end
         default: ok = 1'b0;
      endcase
      e.imm = 32'(v);
      e.ill = !ok;
      if (!ok) begin
         e.ctrl = '0;
         e.imm  = '0;
      end
      return e;
   endfunction

   // One clock: compare at the falling edge, advance the model, then return
   // #1 after the rising edge so the caller can drive the next inputs.
   task automatic cycle();
      ent_t e;
      bit   exp_rdy;
      bit   exp_vld;
      @(negedge clk);
      exp_rdy = (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_vld);
      check("illegal_cnt", illegal_cnt, model_cnt);
      if (exp_vld) begin
         e = exp_q[0];
         check("out_pc", out_pc, e.pc);
         check("out_fields", {out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7}, e.fields);
         check("out_imm", out_imm, e.imm);
         check("out_ctrl", out_ctrl, e.ctrl);
         check("out_illegal", out_illegal, e.ill);
      end
      if (flush) begin
         exp_q.delete();
      end else begin
         if (exp_vld && out_ready) begin
            e = exp_q.pop_front();
            if (e.ill && model_cnt < CNT_MAX) model_cnt++;
         end
         if (in_valid && exp_rdy) exp_q.push_back(model_decode(in_inst, in_pc));
      end
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------ directed vectors
   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [6:0]  ctrl;
      logic        ill;
      logic [4:0]  rd;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];

   initial begin
      vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 7'b1100000, 1'b0, 5'd1};  // addi x1,x0,-1
      vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 7'b0000010, 1'b0, 5'd29}; // beq -4
      vecs[2]  = '{32'h008000EF, 32'h00000008, 7'b1000001, 1'b0, 5'd1};  // jal x1,+8
      vecs[3]  = '{32'h00000000, 32'h00000000, 7'b0000000, 1'b1, 5'd0};  // all zero
`ifdef DECODE_RV32M_EN
      vecs[4]  = '{32'h02000033, 32'h00000000, 7'b1000000, 1'b0, 5'd0};  // mul
`else
      vecs[4]  = '{32'h02000033, 32'h00000000, 7'b0000000, 1'b1, 5'd0};  // mul, no M
`endif
      vecs[5]  = '{32'h123452B7, 32'h12345000, 7'b1100000, 1'b0, 5'd5};  // lui x5
      vecs[6]  = '{32'hFF80A103, 32'hFFFFFFF8, 7'b1110100, 1'b0, 5'd2};  // lw x2,-8(x1)
      vecs[7]  = '{32'h0020A623, 32'h0000000C, 7'b0101000, 1'b0, 5'd12}; // sw x2,12(x1)
      vecs[8]  = '{32'h402081B3, 32'h00000000, 7'b1000000, 1'b0, 5'd3};  // sub
      vecs[9]  = '{32'h4030D093, 32'h00000403, 7'b1100000, 1'b0, 5'd1};  // srai
      vecs[10] = '{32'h40009093, 32'h00000000, 7'b0000000, 1'b1, 5'd1};  // slli bad funct7
      vecs[11] = '{32'h000090E7, 32'h00000000, 7'b0000000, 1'b1, 5'd1};  // jalr funct3=1
      vecs[12] = '{32'h00002063, 32'h00000000, 7'b0000000, 1'b1, 5'd0};  // branch funct3=2
      vecs[13] = '{32'h00001097, 32'h00001000, 7'b1100000, 1'b0, 5'd1};  // auipc x1,1
   end

   // ------------------------------------------------------ main sequence
   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  op;
      logic [6:0]  f7;
      w = $urandom;
      case ($urandom_range(0, 9))
         0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
         5: op = 7'h37; 6: op = 7'h17; 7: op = 7'h6F; 8: op = 7'h67;
         default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01; default: f7 = 7'($urandom);
      endcase
      w[6:0]   = op;
      w[31:25] = f7;
      return w;
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // reset state
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_cnt", illegal_cnt, 0);
      check("rst_payload", {out_pc, out_imm, out_ctrl, out_illegal}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // table-driven decode, one instruction at a time
      for (int i = 0; i < NV; i++) begin
         in_inst   = vecs[i].inst;
         in_pc     = 32'(i * 4);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         cycle();
         in_valid = 1'b0;
         check("vec_valid", out_valid, 1'b1);
         check("vec_imm", out_imm, vecs[i].imm);
         check("vec_ctrl", out_ctrl, vecs[i].ctrl);
         check("vec_illegal", out_illegal, vecs[i].ill);
         check("vec_rd", out_rd, vecs[i].rd);
         cycle();
      end

      // skid backpressure: three offered, two held, strict order on release
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_inst  = vecs[(i * 5) % NV].inst;
         in_pc    = 32'h100 + 32'(i * 4);
         cycle();
      end
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_head_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      repeat (3) cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      check("bp_drained", out_valid, 1'b0);

      // flush with entries held and a new input offered
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_inst  = 32'h00000000;
         in_pc    = 32'h200 + 32'(i * 4);
         cycle();
      end
      in_inst = 32'hFFF00093;
      in_pc   = 32'h208;
      flush   = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 32'h008000EF;
      in_pc     = 32'h20C;
      cycle();
      in_valid = 1'b0;
      check("post_flush_pc", out_pc, 32'h20C);
      repeat (4) cycle();

      // asynchronous reset while an entry is held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00000000;
      in_pc     = 32'h300;
      cycle();
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_cnt", illegal_cnt, 0);
      check("midrst_in_ready", in_ready, 1'b0);
      exp_q.delete();
      model_cnt = 0;
      in_valid  = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         cycle();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      // illegal counter saturation
      in_valid  = 1'b1;
      in_inst   = 32'h00000000;
      out_ready = 1'b1;
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         in_pc = 32'(i);
         cycle();
      end
      in_valid = 1'b0;
      repeat (3) cycle();
      check("cnt_saturated", illegal_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
